// File: rtl/sdram_cmd_pkg.sv
// Shared types for the SDRAM command monitor: command codes, device states,
// violation bit positions and the bus decode helpers.
package sdram_cmd_pkg;

    // Command codes match {cs_n, ras_n, cas_n, we_n}; DESELECT gets its own code.
    typedef enum logic [3:0] {
        CMD_LOAD_MODE    = 4'b0000,
        CMD_AUTO_REFRESH = 4'b0001,
        CMD_PRECHARGE    = 4'b0010,
        CMD_ACTIVE       = 4'b0011,
        CMD_WRITE        = 4'b0100,
        CMD_READ         = 4'b0101,
        CMD_BURST_STOP   = 4'b0110,
        CMD_NOP          = 4'b0111,
        CMD_DESELECT     = 4'b1111
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACT  = 3'd1,
        ST_AREF = 3'd2,
        ST_SREF = 3'd3,
        ST_SXIT = 3'd4
    } state_e;

    localparam int VIOL_BUSY       = 0;
    localparam int VIOL_SREF_CMD   = 1;
    localparam int VIOL_SREF_SHORT = 2;
    localparam int VIOL_OPEN_BANK  = 3;

    // cs_n high masks the rest of the bus.
    function automatic cmd_e decode_cmd(input logic [3:0] bus);
        if (bus[3]) return CMD_DESELECT;
        return cmd_e'(bus);
    endfunction

    // True for anything that actually asks the device to do work.
    function automatic logic is_real_cmd(input cmd_e c);
        return (c != CMD_NOP) && (c != CMD_DESELECT);
    endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// Per-bank open/closed flags. ACTIVE opens a bank, PRECHARGE closes one bank
// or all of them, and a refresh forces everything closed.
module sdram_bank_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       act_i,
    input  logic       pre_i,
    input  logic       pre_all_i,
    input  logic [1:0] ba_i,
    input  logic       force_clr_i,
    output logic [3:0] bank_open_o,
    output logic [3:0] bank_open_next_o
);

    logic [3:0] bank_open_q;
    logic [3:0] bank_open_d;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            // Force-clear dominates; ACTIVE and PRECHARGE never coincide on one bus cycle.
            assign bank_open_d[gi] = force_clr_i                            ? 1'b0 :
                                     (act_i && (ba_i == 2'(gi)))            ? 1'b1 :
                                     (pre_i && (pre_all_i || ba_i == 2'(gi))) ? 1'b0 :
                                     bank_open_q[gi];
        end
    endgenerate

    // Bank flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank_open_q <= '0;
        else        bank_open_q <= bank_open_d;
    end

    assign bank_open_o      = bank_open_q;
    assign bank_open_next_o = bank_open_d;

endmodule

// File: rtl/sdram_cmd_monitor.sv
// SDRAM command bus monitor: decodes commands, tracks power state and bank
// status, times tRFC / tXSR / self-refresh residency and latches violations.
// Optional: define SDRAM_MON_STATS_EN to enable refresh/self-refresh counters.
module sdram_cmd_monitor
    import sdram_cmd_pkg::*;
#(
    parameter int T_RFC      = 7,
    parameter int T_XSR      = 8,
    parameter int T_SREF_MIN = 4,
    parameter int CNT_W      = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             sdram_cke,
    input  logic [3:0]       sdram_cmd,
    input  logic [1:0]       sdram_ba,
    input  logic [11:0]      sdram_addr,
    input  logic             viol_clr,
    output logic [3:0]       cmd_code,
    output logic             cmd_valid,
    output logic [2:0]       dev_state,
    output logic [3:0]       bank_open,
    output logic             sref_active,
    output logic [CNT_W-1:0] sref_cycles,
    output logic             exit_ready,
    output logic [3:0]       viol_flags,
    output logic [15:0]      aref_count,
    output logic [15:0]      sref_count
);

    localparam int TW = 8;

    cmd_e             cmd_dec;
    logic             real_cmd;
    logic             cke_q;
    state_e           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] sref_cyc_q, sref_cyc_d;
    logic             exit_ready_q, exit_ready_d;
    logic [3:0]       viol_q, viol_d, viol_new;
    cmd_e             cmd_code_q;
    logic             cmd_valid_q;
    logic             sref_active_q;
    logic             track_en, force_clr;
    logic [3:0]       bank_open_w, bank_next_w;
    logic             unused_addr;

    assign cmd_dec     = decode_cmd(sdram_cmd);
    assign real_cmd    = is_real_cmd(cmd_dec);
    assign unused_addr = ^{sdram_addr[11], sdram_addr[9:0]};

    sdram_bank_tracker u_banks (
        .clk              (sys_clk),
        .rst_n            (sys_rst_n),
        .act_i            (track_en && (cmd_dec == CMD_ACTIVE)),
        .pre_i            (track_en && (cmd_dec == CMD_PRECHARGE)),
        .pre_all_i        (sdram_addr[10]),
        .ba_i             (sdram_ba),
        .force_clr_i      (force_clr),
        .bank_open_o      (bank_open_w),
        .bank_open_next_o (bank_next_w)
    );

    // Next-state logic; CKE low outside self-refresh freezes everything (power-down).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sref_cyc_d   = sref_cyc_q;
        exit_ready_d = exit_ready_q;
        viol_new     = '0;
        track_en     = 1'b0;
        force_clr    = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACT: begin
                if (sdram_cke) begin
                    track_en = 1'b1;
                    if (cmd_dec == CMD_AUTO_REFRESH) begin
                        state_d   = ST_AREF;
                        cnt_d     = TW'(T_RFC - 1);
                        force_clr = 1'b1;
                        viol_new[VIOL_OPEN_BANK] = |bank_open_w;
                    end else begin
                        state_d = (bank_next_w != 4'b0) ? ST_ACT : ST_IDLE;
                    end
                end else if (cke_q && cmd_dec == CMD_AUTO_REFRESH) begin
                    state_d    = ST_SREF;
                    sref_cyc_d = CNT_W'(1);
                    force_clr  = 1'b1;
                    viol_new[VIOL_OPEN_BANK] = |bank_open_w;
                end
            end
            ST_AREF: begin
                if (sdram_cke) begin
                    track_en = 1'b1;
                    viol_new[VIOL_BUSY] = real_cmd;
                    if (cnt_q == '0) state_d = ST_IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_SREF: begin
                if (sdram_cke) begin
                    state_d      = ST_SXIT;
                    cnt_d        = TW'(T_XSR - 1);
                    exit_ready_d = 1'b0;
                    viol_new[VIOL_SREF_SHORT] = (sref_cyc_q < CNT_W'(T_SREF_MIN));
                end else begin
                    viol_new[VIOL_SREF_CMD] = real_cmd;
                    if (sref_cyc_q != '1) sref_cyc_d = sref_cyc_q + 1'b1;
                end
            end
            ST_SXIT: begin
                if (sdram_cke) begin
                    track_en = 1'b1;
                    viol_new[VIOL_BUSY] = real_cmd;
                    if (cnt_q == '0) begin
                        state_d      = ST_IDLE;
                        exit_ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh violation outranks a simultaneous clear.
        viol_d = (viol_clr ? 4'b0 : viol_q) | viol_new;
    end

    // State, timer, flag and decode registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cke_q         <= 1'b1;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            sref_cyc_q    <= '0;
            exit_ready_q  <= 1'b1;
            viol_q        <= '0;
            cmd_code_q    <= CMD_NOP;
            cmd_valid_q   <= 1'b0;
            sref_active_q <= 1'b0;
        end else begin
            cke_q         <= sdram_cke;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sref_cyc_q    <= sref_cyc_d;
            exit_ready_q  <= exit_ready_d;
            viol_q        <= viol_d;
            cmd_code_q    <= cmd_dec;
            cmd_valid_q   <= real_cmd;
            sref_active_q <= (state_d == ST_SREF);
        end
    end

`ifdef SDRAM_MON_STATS_EN
    logic        idle_grp, aref_hit, sref_hit;
    logic [15:0] aref_cnt_q, sref_cnt_q;

    assign idle_grp = (state_q == ST_IDLE) || (state_q == ST_ACT);
    assign aref_hit = idle_grp && sdram_cke && (cmd_dec == CMD_AUTO_REFRESH);
    assign sref_hit = idle_grp && cke_q && !sdram_cke && (cmd_dec == CMD_AUTO_REFRESH);

    // Saturating refresh / self-refresh entry counters, cleared only by reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            aref_cnt_q <= '0;
            sref_cnt_q <= '0;
        end else begin
            if (aref_hit && aref_cnt_q != 16'hFFFF) aref_cnt_q <= aref_cnt_q + 16'd1;
            if (sref_hit && sref_cnt_q != 16'hFFFF) sref_cnt_q <= sref_cnt_q + 16'd1;
        end
    end

    assign aref_count = aref_cnt_q;
    assign sref_count = sref_cnt_q;
`else
    assign aref_count = '0;
    assign sref_count = '0;
`endif

    assign cmd_code    = cmd_code_q;
    assign cmd_valid   = cmd_valid_q;
    assign dev_state   = state_q;
    assign bank_open   = bank_open_w;
    assign sref_active = sref_active_q;
    assign sref_cycles = sref_cyc_q;
    assign exit_ready  = exit_ready_q;
    assign viol_flags  = viol_q;

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Directed bench for sdram_cmd_monitor with hand-computed expectations.
module tb_sdram_cmd_monitor;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_READ = 4'b0101;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam int S_IDLE = 0, S_ACT = 1, S_AREF = 2, S_SREF = 3, S_SXIT = 4;

    logic        sys_clk, sys_rst_n;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;
    logic        viol_clr;
    logic [3:0]  cmd_code;
    logic        cmd_valid;
    logic [2:0]  dev_state;
    logic [3:0]  bank_open;
    logic        sref_active;
    logic [15:0] sref_cycles;
    logic        exit_ready;
    logic [3:0]  viol_flags;
    logic [15:0] aref_count, sref_count;

    int n_checks = 0;
    int n_pass   = 0;

    sdram_cmd_monitor dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .sdram_cke   (sdram_cke),
        .sdram_cmd   (sdram_cmd),
        .sdram_ba    (sdram_ba),
        .sdram_addr  (sdram_addr),
        .viol_clr    (viol_clr),
        .cmd_code    (cmd_code),
        .cmd_valid   (cmd_valid),
        .dev_state   (dev_state),
        .bank_open   (bank_open),
        .sref_active (sref_active),
        .sref_cycles (sref_cycles),
        .exit_ready  (exit_ready),
        .viol_flags  (viol_flags),
        .aref_count  (aref_count),
        .sref_count  (sref_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("[%0t] ok   %s = %0h", $time, tag, got);
        end else begin
            $display("[%0t] FAIL %s got=%0h expected=%0h", $time, tag, got, exp);
        end
    endtask

    // One bus cycle: drive, wait for the sampling edge, settle past it.
    task automatic step(input logic cke, input logic [3:0] cmd, input logic [1:0] ba,
                        input logic a10, input logic clr);
        sdram_cke  = cke;
        sdram_cmd  = cmd;
        sdram_ba   = ba;
        sdram_addr = {1'b0, a10, 10'd0};
        viol_clr   = clr;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        sdram_cke  = 1'b1;
        sdram_cmd  = C_NOP;
        sdram_ba   = 2'd0;
        sdram_addr = '0;
        viol_clr   = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_state",      32'(dev_state),   S_IDLE);
        check("rst_cmd_code",   32'(cmd_code),    32'h7);
        check("rst_cmd_valid",  32'(cmd_valid),   0);
        check("rst_bank_open",  32'(bank_open),   0);
        check("rst_sref_act",   32'(sref_active), 0);
        check("rst_sref_cyc",   32'(sref_cycles), 0);
        check("rst_exit_ready", 32'(exit_ready),  1);
        check("rst_viol",       32'(viol_flags),  0);
        sys_rst_n = 1'b1;
        step(1, C_NOP, 0, 0, 0);

        // Self-refresh entry, 10 cycles low, clean exit.
        step(0, C_AREF, 0, 0, 0);
        check("sref_entry_state", 32'(dev_state),   S_SREF);
        check("sref_entry_cyc",   32'(sref_cycles), 1);
        check("sref_entry_act",   32'(sref_active), 1);
        check("sref_entry_valid", 32'(cmd_valid),   1);
        check("sref_entry_code",  32'(cmd_code),    32'h1);
        repeat (9) step(0, C_NOP, 0, 0, 0);
        check("sref_cyc_10", 32'(sref_cycles), 10);
        step(1, C_NOP, 0, 0, 0);
        check("sxit_state",      32'(dev_state),   S_SXIT);
        check("sxit_exit_ready", 32'(exit_ready),  0);
        check("sxit_sref_act",   32'(sref_active), 0);
        check("sxit_sref_cyc",   32'(sref_cycles), 10);
        for (int i = 0; i < 8; i++) begin
            step(1, C_NOP, 0, 0, 0);
            check($sformatf("txsr_ready_%0d", i), 32'(exit_ready), (i == 7) ? 1 : 0);
            check($sformatf("txsr_state_%0d", i), 32'(dev_state), (i == 7) ? S_IDLE : S_SXIT);
        end
        check("clean_exit_viol", 32'(viol_flags), 0);

        // Early exit, then ACTIVE inside tXSR.
        step(0, C_AREF, 0, 0, 0);
        step(0, C_NOP, 0, 0, 0);
        step(1, C_NOP, 0, 0, 0);
        check("early_viol",  32'(viol_flags),  32'h4);
        check("early_state", 32'(dev_state),   S_SXIT);
        check("early_cyc",   32'(sref_cycles), 2);
        step(1, C_NOP, 0, 0, 0);
        step(1, C_NOP, 0, 0, 0);
        step(1, C_ACT, 1, 0, 0);
        check("txsr_cmd_valid", 32'(cmd_valid),  1);
        check("txsr_cmd_code",  32'(cmd_code),   32'h3);
        check("txsr_viol",      32'(viol_flags), 32'h5);
        check("txsr_bank",      32'(bank_open),  32'h2);
        step(1, C_NOP, 0, 0, 0);
        check("nop_valid", 32'(cmd_valid), 0);
        repeat (5) step(1, C_NOP, 0, 0, 0);
        check("post_sxit_act", 32'(dev_state), S_ACT);
        step(1, C_PRE, 1, 0, 0);
        check("pre_one_bank",  32'(bank_open), 0);
        check("pre_one_state", 32'(dev_state), S_IDLE);
        step(1, C_NOP, 0, 0, 1);
        check("clr_viol_1", 32'(viol_flags), 0);

        // Refresh with an open bank.
        step(1, C_ACT, 2, 0, 0);
        check("open_bank_2",   32'(bank_open), 32'h4);
        check("open_state",    32'(dev_state), S_ACT);
        step(1, C_AREF, 0, 0, 0);
        check("open_aref_viol",  32'(viol_flags), 32'h8);
        check("open_aref_bank",  32'(bank_open),  0);
        check("open_aref_state", 32'(dev_state),  S_AREF);
        for (int i = 0; i < 7; i++) begin
            step(1, C_NOP, 0, 0, 0);
            check($sformatf("trfc_state_%0d", i), 32'(dev_state), (i == 6) ? S_IDLE : S_AREF);
        end
        step(1, C_NOP, 0, 0, 1);
        check("clr_viol_2", 32'(viol_flags), 0);

        // Command in AREF together with viol_clr: the new violation survives.
        step(1, C_AREF, 0, 0, 0);
        check("aref2_viol", 32'(viol_flags), 0);
        step(1, C_READ, 0, 0, 1);
        check("clr_vs_busy", 32'(viol_flags), 32'h1);
        repeat (6) step(1, C_NOP, 0, 0, 0);
        check("aref2_done", 32'(dev_state), S_IDLE);
        step(1, C_NOP, 0, 0, 1);
        check("clr_viol_3", 32'(viol_flags), 0);

        // Precharge-all.
        step(1, C_ACT, 0, 0, 0);
        step(1, C_ACT, 3, 0, 0);
        check("two_banks",   32'(bank_open), 32'h9);
        step(1, C_PRE, 1, 1, 0);
        check("pre_all_bank",  32'(bank_open), 0);
        check("pre_all_state", 32'(dev_state), S_IDLE);

        // Power-down: CKE low without a refresh holds state quietly.
        repeat (3) step(0, C_NOP, 0, 0, 0);
        check("pd_state", 32'(dev_state),   S_IDLE);
        check("pd_sref",  32'(sref_active), 0);
        check("pd_viol",  32'(viol_flags),  0);
        step(1, C_NOP, 0, 0, 0);

        // Command during self-refresh, clear, then async reset in SXIT.
        step(0, C_AREF, 0, 0, 0);
        step(0, C_READ, 0, 0, 0);
        check("sref_cmd_viol", 32'(viol_flags), 32'h2);
        check("sref_cmd_code", 32'(cmd_code),   32'h5);
        repeat (3) step(0, C_NOP, 0, 0, 0);
        step(1, C_NOP, 0, 0, 0);
        check("sxit2_state", 32'(dev_state),  S_SXIT);
        check("sxit2_viol",  32'(viol_flags), 32'h2);
        step(1, C_NOP, 0, 0, 1);
        check("clr_viol_4",  32'(viol_flags), 0);
        check("sxit2_ready", 32'(exit_ready), 0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(dev_state),   S_IDLE);
        check("async_rst_ready", 32'(exit_ready),  1);
        check("async_rst_cyc",   32'(sref_cycles), 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_monitor.md
Name: sdram_cmd_monitor

Overview:
- Device-side decoder/checker for the SDRAM command bus (cke, cmd, ba, addr) driven by the controller's init, self-refresh and auto-refresh blocks.
- Registers each decoded command and tracks device power state: idle, bank active, auto-refresh busy, self-refresh, self-refresh exit.
- Enforces tRFC, tXSR and minimum self-refresh residency, and flags protocol violations.
- Synthesizable; sits beside the SDRAM pins in simulation and in the FPGA debug build.

Parameters:
- T_RFC, 7, cycles after AUTO_REFRESH during which only NOP/DESELECT is allowed.
- T_XSR, 8, cycles after the CKE rise (self-refresh exit) during which only NOP/DESELECT is allowed.
- T_SREF_MIN, 4, minimum cycles with CKE low before a legal exit.
- CNT_W, 16, width of the self-refresh residency counter.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- sdram_cke  in  1  SDRAM clock enable.
- sdram_cmd  in  4  {cs_n, ras_n, cas_n, we_n}.
- sdram_ba  in  2  bank address.
- sdram_addr  in  12  address; bit 10 is the precharge-all flag.
- viol_clr  in  1  synchronous clear of viol_flags.
- cmd_code  out  4  registered decoded command (package enum).
- cmd_valid  out  1  pulse: a non-NOP/non-DESELECT command was decoded.
- dev_state  out  3  current state (package enum).
- bank_open  out  4  per-bank open flags.
- sref_active  out  1  high while state == SREF.
- sref_cycles  out  CNT_W  cycles spent in the current or last self-refresh; saturating.
- exit_ready  out  1  high once tXSR has elapsed after a self-refresh exit.
- viol_flags  out  4  sticky violation bits.

Behaviour:
- Reset values: cmd_code = NOP, cmd_valid = 0, dev_state = IDLE, bank_open = 0, sref_active = 0, sref_cycles = 0, exit_ready = 1, viol_flags = 0, cke_q = 1.
- cke_q holds sdram_cke delayed one cycle. All outputs are registered, so there is one cycle of latency from a bus sample.
- Decode (cs_n = 1 means DESELECT): 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE, 0110 BURST_STOP.
- Bank tracking:
  - ACTIVE sets bank_open[ba].
  - PRECHARGE clears bank_open[ba], or all four bits if addr[10] = 1.
  - Tracking is ignored in SREF.
- IDLE / ACT (ACT when bank_open != 0):
  - AUTO_REFRESH with sdram_cke = 1 -> AREF; counter loads T_RFC-1.
  - AUTO_REFRESH with cke_q = 1 and sdram_cke = 0 -> SREF; sref_cycles clears to 1.
- AREF: the counter decrements; at 0 -> IDLE. Any non-NOP/DESELECT command in AREF sets viol[0].
- SREF:
  - sref_cycles increments each cycle and saturates at all-ones.
  - A command other than NOP/DESELECT while CKE is low sets viol[1].
  - A CKE rise (cke_q = 0, sdram_cke = 1) -> SXIT; counter loads T_XSR-1; exit_ready goes to 0.
  - If sref_cycles < T_SREF_MIN at that rise, also set viol[2].
- SXIT: the counter decrements; at 0 -> IDLE and exit_ready goes to 1. A non-NOP/DESELECT command in SXIT sets viol[0], and the command is still decoded.
- Refresh with open bank: AUTO_REFRESH, or self-refresh entry, while bank_open != 0 sets viol[3]. The state transition still occurs, and bank_open is forced to 0.
- CKE low outside a self-refresh entry: treated as power-down. State is held, no counting, no violation.
- Simultaneous viol_clr and a new violation: the new violation wins, so the bit stays set.
- Reset mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
- SDRAM_MON_STATS_EN defined: adds outputs aref_count[15:0] and sref_count[15:0]. These are saturating counts of AUTO_REFRESH commands and self-refresh entries, cleared only by reset.
- Not defined: the ports still exist and are tied to 0, and no counter logic is generated.

Decomposition:
- Package sdram_cmd_pkg holds:
  - the cmd_e enum with the encodings above, plus DESELECT as its own code;
  - the state_e enum (IDLE, ACT, AREF, SREF, SXIT);
  - violation bit index constants VIOL_BUSY = 0, VIOL_SREF_CMD = 1, VIOL_SREF_SHORT = 2, VIOL_OPEN_BANK = 3.
- Sub-module sdram_bank_tracker holds the registered bank_open vector, with ACTIVE/PRECHARGE/force-clear inputs.

Test Plan:
- Entry/exit: reset, then AUTO_REFRESH with CKE 1 -> 0, hold CKE low 10 cycles, raise CKE, then 8 NOPs.
  - dev_state goes SREF -> SXIT -> IDLE.
  - sref_cycles = 10; exit_ready low for 8 cycles then 1; viol_flags = 0.
- Early exit: CKE low for 2 cycles, then high -> viol_flags[2] = 1, state SXIT.
- Command in tXSR: ACTIVE issued 3 cycles after the CKE rise -> viol_flags[0] = 1 and cmd_valid pulse with cmd_code = ACTIVE.
- Open bank: ACTIVE ba = 2, then AUTO_REFRESH -> bank_open = 4'b0100 before the refresh, viol_flags[3] = 1, bank_open = 0, state AREF for 7 cycles.
- Precharge-all: ACTIVE ba = 0 and ba = 3, then PRECHARGE with addr[10] = 1 -> bank_open = 0, state IDLE.
- Clear and reset: set viol[1] by issuing READ with CKE low in SREF, then pulse viol_clr -> flags 0. Assert sys_rst_n low during SXIT -> dev_state = IDLE and exit_ready = 1 immediately.
